zpu_sd_sched: RTL and testbench
===============================

# zpu_sd_sched

Sequencer between the ZPU disk-I/O register interface and the hps_io virtual-disk handshake (sd_lba/sd_rd/sd_wr/sd_ack). It turns ZPU block read/write request edges into a single outstanding per-drive sd_rd/sd_wr pulse-and-hold and tracks sd_ack through the sector transfer. It reports completion and timeout status back to the ZPU. It sits in emu beside the 512-byte sector buffer and replaces ad-hoc request logic, adding serialisation, bounds checking and a hang-proof timeout.

## Interface
Parameters:
- VDNUM, 3, number of virtual drives (width of sd_rd/sd_wr)
- TO_BITS, 24, timeout counter width; timeout = 2^TO_BITS-1 cycles

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_rd  in  1  block-read request level (ZPU_OUT2[1]); rising edge starts a read
- req_wr  in  1  block-write request level (ZPU_OUT2[2]); rising edge starts a write
- drv_num  in  3  ZPU drive number; slot = {drv_num[2], drv_num[0]}
- lba_wr  in  1  one-cycle strobe: load lba_in
- lba_in  in  32  sector address
- sd_lba  out  32  sector address to hps_io
- sd_rd  out  VDNUM  per-drive read request
- sd_wr  out  VDNUM  per-drive write request
- sd_ack  in  1  hps_io acknowledge, high for whole transfer
- io_done  out  1  1 = idle/complete, 0 = request in progress
- io_err  out  1  last request failed (bad slot or timeout)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, XFER.
- Edge detect: req_rd_q/req_wr_q registered each cycle; rise = req & ~req_q. Registers update in every state, so a level held high across a request never re-triggers.
- IDLE, read or write rise:
  - slot < VDNUM: latch dir and slot, set sd_rd[slot] or sd_wr[slot], io_done<=0, io_err<=0, clear timer, go REQ.
  - slot >= VDNUM: stay IDLE, io_err<=1, io_done stays 1.
- Simultaneous rd and wr rise: read wins; write edge is discarded.
- REQ: hold request bit. On sd_ack=1, clear all sd_rd/sd_wr and go XFER. If the timer saturates first, clear request bits, io_err<=1, io_done<=1, go IDLE.
- XFER: wait for sd_ack=0, then io_done<=1 and go IDLE. The timer also runs here; a timeout has the same effect as in REQ.
- Request edges seen in REQ/XFER are ignored. No queueing.
- lba_wr loads sd_lba only when busy=0; when busy, the strobe is ignored so the address stays stable for hps_io.
- Only one bit of sd_rd|sd_wr is ever high.

## Timing
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, io_done=1, io_err=0, busy=0, state IDLE, req_*_q=0.
- Request latency: req sampled high at edge N (low at N-1) gives sd_rd/sd_wr bit and io_done=0 visible after edge N.
- sd_ack high sampled at edge M gives request bits 0 after edge M.
- sd_ack low sampled at edge K gives io_done=1 and busy=0 after edge K.
- lba_wr at edge N gives sd_lba updated after edge N.
- Timer is TO_BITS wide, increments each cycle in REQ/XFER, and fires when it reaches all-ones. No wrap.
- Reset mid-transfer: outputs return to reset values on the next edge. A late sd_ack is ignored in IDLE.

## Structure
- Package zpu_sd_pkg: state enum (IDLE, REQ, XFER), slot function drv_num→{[2],[0]}, default TO_BITS.
- No sub-module. Edge detectors and timer are inline.

## Test plan
- Read D1: lba_wr with 0x00000123, then req_rd rise with drv_num=0 → sd_lba=0x123, sd_rd=001 next cycle, io_done=0. After sd_ack pulses high for 10 cycles, sd_rd=000 and io_done=1 one cycle after ack falls.
- Write with drv_num=5 (slot 3, VDNUM=3) → no sd_wr bit, io_err=1, io_done=1. With drv_num=4 → sd_wr=100.
- req_rd and req_wr rise on the same cycle with drv_num=1 → sd_rd=010, sd_wr=000. A second req_wr rise during XFER produces no new request.
- TO_BITS=4, no sd_ack → request drops after 15 cycles, io_err=1, io_done=1. A later ack is ignored with state IDLE.
- lba_wr 0xDEADBEEF while busy → sd_lba unchanged. Assert reset during XFER → all outputs at reset values next cycle.

Source files
------------

// File: rtl/zpu_sd_pkg.sv
// Shared types and defaults for the ZPU virtual-disk request sequencer.
// Holds the sequencer state enum, the drive-number to slot mapping and default sizes.
// No logic of its own; imported by zpu_sd_sched.
package zpu_sd_pkg;

    localparam int VDNUM_DEF   = 3;
    localparam int TO_BITS_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } sd_state_t;

    // ZPU drive numbers map onto hps_io slots through bits 2 and 0 only.
    function automatic logic [1:0] drv_slot(input logic [2:0] drv);
        return {drv[2], drv[0]};
    endfunction

endpackage

// File: rtl/zpu_sd_sched.sv
// Serialises ZPU block read/write requests onto the per-drive hps_io sd_rd/sd_wr handshake.
// Latency: request edge to sd_rd/sd_wr bit is 1 cycle; ack fall to io_done is 1 cycle.
// No queueing: request edges arriving while busy are dropped; a timeout frees a hung drive.
import zpu_sd_pkg::*;

module zpu_sd_sched #(
    parameter int VDNUM   = VDNUM_DEF,
    parameter int TO_BITS = TO_BITS_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [2:0]        drv_num,
    input  logic              lba_wr,
    input  logic [31:0]       lba_in,
    output logic [31:0]       sd_lba,
    output logic [VDNUM-1:0]  sd_rd,
    output logic [VDNUM-1:0]  sd_wr,
    input  logic              sd_ack,
    output logic              io_done,
    output logic              io_err,
    output logic              busy
);

    sd_state_t          state;
    logic               req_rd_q;
    logic               req_wr_q;
    logic [TO_BITS-1:0] timer;

    logic               rd_rise;
    logic               wr_rise;
    logic [1:0]         slot;
    logic               slot_ok;
    logic [VDNUM-1:0]   slot_bit;
    logic [TO_BITS-1:0] timer_nx;
    logic               to_fire;

    assign rd_rise  = req_rd & ~req_rd_q;
    assign wr_rise  = req_wr & ~req_wr_q;
    assign slot     = drv_slot(drv_num);
    assign slot_ok  = int'(slot) < VDNUM;
    assign slot_bit = VDNUM'(1) << slot;
    assign timer_nx = timer + TO_BITS'(1);
    // Fires on the cycle the timer would reach all-ones, so it never wraps.
    assign to_fire  = &timer_nx;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            req_rd_q <= 1'b0;
            req_wr_q <= 1'b0;
            timer    <= '0;
            sd_lba   <= '0;
            sd_rd    <= '0;
            sd_wr    <= '0;
            io_done  <= 1'b1;
            io_err   <= 1'b0;
        end else begin
            req_rd_q <= req_rd;
            req_wr_q <= req_wr;

            // Address is frozen while hps_io may still be using it.
            if (lba_wr && state == IDLE)
                sd_lba <= lba_in;

            case (state)
                IDLE: begin
                    if (rd_rise || wr_rise) begin
                        if (slot_ok) begin
                            sd_rd   <= rd_rise ? slot_bit : '0;
                            sd_wr   <= rd_rise ? '0 : slot_bit;
                            io_done <= 1'b0;
                            io_err  <= 1'b0;
                            timer   <= '0;
                            state   <= REQ;
                        end else begin
                            io_err  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    timer <= timer_nx;
                    if (sd_ack) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        state <= XFER;
                    end else if (to_fire) begin
                        sd_rd   <= '0;
                        sd_wr   <= '0;
                        io_err  <= 1'b1;
                        io_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                XFER: begin
                    timer <= timer_nx;
                    if (!sd_ack) begin
                        io_done <= 1'b1;
                        state   <= IDLE;
                    end else if (to_fire) begin
                        io_err  <= 1'b1;
                        io_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    sd_rd <= '0;
                    sd_wr <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zpu_sd_sched.sv
// Directed bench for zpu_sd_sched: a default-timeout instance and a TO_BITS=4 instance
// share stimulus; a transaction-level model predicts both every cycle.
module tb_zpu_sd_sched;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        req_rd  = 1'b0;
    logic        req_wr  = 1'b0;
    logic [2:0]  drv_num = 3'd0;
    logic        lba_wr  = 1'b0;
    logic [31:0] lba_in  = 32'd0;
    logic        sd_ack  = 1'b0;

    logic [31:0] a_lba, b_lba;
    logic [2:0]  a_rd, a_wr, b_rd, b_wr;
    logic        a_done, a_err, a_busy, b_done, b_err, b_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    zpu_sd_sched u_dut (
        .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
        .drv_num(drv_num), .lba_wr(lba_wr), .lba_in(lba_in), .sd_lba(a_lba),
        .sd_rd(a_rd), .sd_wr(a_wr), .sd_ack(sd_ack), .io_done(a_done),
        .io_err(a_err), .busy(a_busy)
    );

    zpu_sd_sched #(.VDNUM(3), .TO_BITS(4)) u_to (
        .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
        .drv_num(drv_num), .lba_wr(lba_wr), .lba_in(lba_in), .sd_lba(b_lba),
        .sd_rd(b_rd), .sd_wr(b_wr), .sd_ack(sd_ack), .io_done(b_done),
        .io_err(b_err), .busy(b_busy)
    );

    // Transaction model: phase 0 = idle, 1 = waiting for ack, 2 = transferring.
    int          m_phase [2];
    int          m_age   [2];
    int          m_limit [2];
    int          m_slot  [2];
    bit          m_isrd  [2];
    bit          m_done  [2];
    bit          m_err   [2];
    logic [31:0] m_lba   [2];
    bit          m_prd   [2];
    bit          m_pwr   [2];
    bit          armed = 0;

    initial begin
        m_limit[0] = (1 << 24) - 1;
        m_limit[1] = 15;
    end

    always @(posedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] = 0; m_age[i] = 0; m_slot[i] = 0; m_isrd[i] = 0;
                m_done[i] = 1; m_err[i] = 0; m_lba[i] = 32'd0;
                m_prd[i] = 0; m_pwr[i] = 0;
            end else begin
                bit rr, wr;
                int s;
                rr = req_rd && !m_prd[i];
                wr = req_wr && !m_pwr[i];
                m_prd[i] = req_rd;
                m_pwr[i] = req_wr;
                if (lba_wr && m_phase[i] == 0) m_lba[i] = lba_in;
                if (m_phase[i] == 0) begin
                    if (rr || wr) begin
                        s = drv_num[2] * 2 + drv_num[0];
                        if (s < 3) begin
                            m_phase[i] = 1; m_isrd[i] = rr; m_slot[i] = s;
                            m_done[i] = 0; m_err[i] = 0; m_age[i] = 0;
                        end else begin
                            m_err[i] = 1;
                        end
                    end
                end else begin
                    m_age[i] = m_age[i] + 1;
                    if (m_phase[i] == 1 && sd_ack) m_phase[i] = 2;
                    else if (m_phase[i] == 2 && !sd_ack) begin
                        m_phase[i] = 0; m_done[i] = 1;
                    end else if (m_age[i] == m_limit[i]) begin
                        m_phase[i] = 0; m_done[i] = 1; m_err[i] = 1;
                    end
                end
            end
        end
        if (reset) armed = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [31:0] lba, input logic [2:0] rd,
                            input logic [2:0] wr, input logic done, input logic err,
                            input logic bsy);
        logic [2:0] bit_e;
        bit_e = 3'b001 << m_slot[i];
        chk($sformatf("m%0d_lba", i),  lba,  m_lba[i]);
        chk($sformatf("m%0d_rd", i),   {29'd0, rd},
            (m_phase[i] == 1 && m_isrd[i])  ? {29'd0, bit_e} : 32'd0);
        chk($sformatf("m%0d_wr", i),   {29'd0, wr},
            (m_phase[i] == 1 && !m_isrd[i]) ? {29'd0, bit_e} : 32'd0);
        chk($sformatf("m%0d_done", i), {31'd0, done}, {31'd0, m_done[i]});
        chk($sformatf("m%0d_err", i),  {31'd0, err},  {31'd0, m_err[i]});
        chk($sformatf("m%0d_busy", i), {31'd0, bsy},  {31'd0, m_phase[i] != 0});
    endtask

    always @(negedge clk_sys) begin
        if (armed) begin
            cmp_inst(0, a_lba, a_rd, a_wr, a_done, a_err, a_busy);
            cmp_inst(1, b_lba, b_rd, b_wr, b_done, b_err, b_busy);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int cnt;
        repeat (3) tick();
        chk("rst_lba",  a_lba, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd1);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        reset = 1'b0;
        tick();

        // Read on drive 0 with a 10-cycle ack.
        lba_in = 32'h0000_0123; lba_wr = 1'b1; tick(); lba_wr = 1'b0;
        chk("lba_load", a_lba, 32'h123);
        drv_num = 3'd0; req_rd = 1'b1; tick();
        chk("rd_bit",    {29'd0, a_rd}, 32'h1);
        chk("rd_done0",  {31'd0, a_done}, 32'd0);
        chk("rd_busy",   {31'd0, a_busy}, 32'd1);
        repeat (2) tick();
        sd_ack = 1'b1; tick();
        chk("rd_drop",   {29'd0, a_rd}, 32'h0);
        repeat (9) tick();
        chk("rd_xfer_done", {31'd0, a_done}, 32'd0);
        sd_ack = 1'b0; tick();
        chk("rd_done1",  {31'd0, a_done}, 32'd1);
        chk("rd_idle",   {31'd0, a_busy}, 32'd0);
        req_rd = 1'b0; tick();

        // Bad slot, then a good write on drive 4 (slot 2).
        drv_num = 3'd5; req_wr = 1'b1; tick();
        chk("bad_err",  {31'd0, a_err}, 32'd1);
        chk("bad_done", {31'd0, a_done}, 32'd1);
        chk("bad_wr",   {29'd0, a_wr}, 32'h0);
        req_wr = 1'b0; tick();
        drv_num = 3'd4; req_wr = 1'b1; tick();
        chk("wr_bit",   {29'd0, a_wr}, 32'h4);
        chk("wr_err",   {31'd0, a_err}, 32'd0);
        sd_ack = 1'b1; repeat (3) tick();
        sd_ack = 1'b0; tick();
        req_wr = 1'b0; tick();

        // Simultaneous edges: read wins; a write edge during transfer is dropped.
        drv_num = 3'd1; req_rd = 1'b1; req_wr = 1'b1; tick();
        chk("both_rd", {29'd0, a_rd}, 32'h2);
        chk("both_wr", {29'd0, a_wr}, 32'h0);
        req_wr = 1'b0; sd_ack = 1'b1; repeat (2) tick();
        req_wr = 1'b1; tick();
        chk("xfer_wr_ign", {29'd0, a_wr}, 32'h0);
        sd_ack = 1'b0; tick();
        chk("both_done", {31'd0, a_done}, 32'd1);
        chk("both_noretrig", {29'd0, a_wr}, 32'h0);
        req_rd = 1'b0; req_wr = 1'b0; tick();

        // Timeout on the 4-bit instance: request visible for exactly 15 cycles.
        drv_num = 3'd0; req_rd = 1'b1; tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (b_rd == 3'b000) break;
            cnt++;
            tick();
        end
        chk("to_cycles", cnt, 32'd15);
        chk("to_err",  {31'd0, b_err}, 32'd1);
        chk("to_done", {31'd0, b_done}, 32'd1);
        sd_ack = 1'b1; tick();
        chk("late_ack_idle", {31'd0, b_busy}, 32'd0);
        chk("late_ack_rd",   {29'd0, b_rd}, 32'h0);
        sd_ack = 1'b0; tick();
        req_rd = 1'b0; tick();

        // Address frozen while busy, then reset mid-transfer.
        req_rd = 1'b1; tick();
        lba_in = 32'hDEAD_BEEF; lba_wr = 1'b1; tick(); lba_wr = 1'b0;
        chk("lba_frozen", a_lba, 32'h123);
        sd_ack = 1'b1; repeat (2) tick();
        reset = 1'b1; tick();
        chk("rst2_lba",  a_lba, 32'd0);
        chk("rst2_rd",   {29'd0, a_rd}, 32'h0);
        chk("rst2_done", {31'd0, a_done}, 32'd1);
        chk("rst2_err",  {31'd0, a_err}, 32'd0);
        chk("rst2_busy", {31'd0, a_busy}, 32'd0);
        reset = 1'b0; sd_ack = 1'b0; req_rd = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
